// File: rtl/afe_spi_arbiter.sv
// rtl/afe_spi_arbiter.sv - round-robin arbiter serialising requester words onto per-AFE SPI buses
//
// Requesters post a word and a target AFE index. The arbiter grants one
// requester at a time, searching round-robin from the last grant, and
// shifts the word MSB first onto the selected AFE bus. A latch-enable
// pulse follows each word, then a guard gap. Every state lasts CLK_DIV
// sysClk cycles.
//
// Ports:
//   sysClk    in   system clock, all outputs registered on its rising edge
//   sysReset  in   asynchronous active-high reset
//   req       in   [NUM_REQ]             request per requester, held until ack
//   reqData   in   [NUM_REQ*WORD_WIDTH]  word for requester i at [i*WORD_WIDTH +: WORD_WIDTH]
//   reqAfe    in   [NUM_REQ*AFE_W]       target AFE per requester, out of range -> AFE 0
//   ack       out  [NUM_REQ]             one-cycle pulse once the word is latched
//   busy      out                        high from grant through the end of the gap
//   grantIdx  out  [REQ_W]               current or most recent grant
//   spiClk    out  [NUM_AFE]             SPI clock per AFE, idle low
//   spiSdi    out  [NUM_AFE]             SPI data per AFE, idle low
//   spiLe     out  [NUM_AFE]             latch enable per AFE, active high

module afe_spi_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_AFE    = 2,
  parameter int WORD_WIDTH = 16,
  parameter int CLK_DIV    = 50,
  localparam int REQ_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int AFE_W     = (NUM_AFE > 1) ? $clog2(NUM_AFE) : 1
) (
  input  logic                          sysClk,
  input  logic                          sysReset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] reqData,
  input  logic [NUM_REQ*AFE_W-1:0]      reqAfe,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy,
  output logic [REQ_W-1:0]              grantIdx,
  output logic [NUM_AFE-1:0]            spiClk,
  output logic [NUM_AFE-1:0]            spiSdi,
  output logic [NUM_AFE-1:0]            spiLe
);

  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_GAP
  } state_t;

  state_t                state, state_nxt;
  logic [PH_W-1:0]       phase, phase_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
  logic [AFE_W-1:0]      sel_afe, sel_nxt;
  logic [REQ_W-1:0]      last_grant, last_nxt;
  logic [REQ_W-1:0]      grant_nxt;

  logic                  found;
  logic [REQ_W-1:0]      win;
  logic [WORD_WIDTH-1:0] win_data;
  logic [AFE_W-1:0]      win_afe;
  logic                  phase_last;

  logic [NUM_AFE-1:0]    afe_mask;
  logic [NUM_AFE-1:0]    clk_d, sdi_d, le_d;
  logic [NUM_REQ-1:0]    ack_d;
  logic                  busy_d;

  assign phase_last = (phase == PH_W'(CLK_DIV - 1));

  // Round-robin search: first requester above last_grant, else wrap
  // around and take the lowest pending one. This keeps a continuously
  // requesting client from winning twice while another is waiting.
  always_comb begin
    found    = 1'b0;
    win      = last_grant;
    win_data = '0;
    win_afe  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (REQ_W'(i) > last_grant)) begin
        found = 1'b1;
        win   = REQ_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = REQ_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == REQ_W'(i)) begin
        win_data = reqData[i*WORD_WIDTH +: WORD_WIDTH];
        win_afe  = reqAfe[i*AFE_W +: AFE_W];
      end
    end
  end

  // State register (control, datapath and registered outputs)
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state      <= S_IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      sel_afe    <= '0;
      grantIdx   <= '0;
      last_grant <= REQ_W'(NUM_REQ - 1);
      ack        <= '0;
      busy       <= 1'b0;
      spiClk     <= '0;
      spiSdi     <= '0;
      spiLe      <= '0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      sel_afe    <= sel_nxt;
      grantIdx   <= grant_nxt;
      last_grant <= last_nxt;
      ack        <= ack_d;
      busy       <= busy_d;
      spiClk     <= clk_d;
      spiSdi     <= sdi_d;
      spiLe      <= le_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sel_nxt   = sel_afe;
    grant_nxt = grantIdx;
    last_nxt  = last_grant;
    if (state == S_IDLE) begin
      if (found) begin
        state_nxt = S_SETUP;
        phase_nxt = '0;
        bit_nxt   = '0;
        shreg_nxt = win_data;
        sel_nxt   = (int'(win_afe) < NUM_AFE) ? win_afe : '0;
        grant_nxt = win;
        last_nxt  = win;
      end
    end else if (phase_last) begin
      phase_nxt = '0;
      case (state)
        S_SETUP: state_nxt = S_HIGH;
        S_HIGH: begin
          // Advance on the falling edge so the next bit gets a full
          // half-period of setup before the following rising edge; the
          // zero fill leaves SDI low after the last bit.
          state_nxt = S_LOW;
          shreg_nxt = shreg << 1;
        end
        S_LOW: begin
          if (bit_cnt != BIT_W'(WORD_WIDTH - 1)) begin
            bit_nxt   = bit_cnt + 1'b1;
            state_nxt = S_HIGH;
          end else begin
            state_nxt = S_LATCH;
          end
        end
        S_LATCH: state_nxt = S_GAP;
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      phase_nxt = phase + 1'b1;
    end
  end

  // Output logic: decoded from the next state so the pins are flop
  // outputs aligned with the state they belong to.
  always_comb begin
    afe_mask = NUM_AFE'(1) << sel_nxt;
    clk_d    = '0;
    sdi_d    = '0;
    le_d     = '0;
    ack_d    = '0;
    busy_d   = (state_nxt != S_IDLE);
    case (state_nxt)
      S_SETUP, S_LOW: begin
        if (shreg_nxt[WORD_WIDTH-1]) sdi_d = afe_mask;
      end
      S_HIGH: begin
        clk_d = afe_mask;
        if (shreg_nxt[WORD_WIDTH-1]) sdi_d = afe_mask;
      end
      S_LATCH: le_d = afe_mask;
      default: ;
    endcase
    if ((state == S_LATCH) && (state_nxt == S_GAP)) begin
      ack_d = NUM_REQ'(1) << grantIdx;
    end
  end

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// tb/tb_afe_spi_arbiter.sv - randomized self-checking bench for afe_spi_arbiter

module tb_afe_spi_arbiter;

  localparam int NR = 3;
  localparam int NA = 3;
  localparam int W  = 16;
  localparam int H  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: 3 requesters, 3 AFEs (2-bit index field, value 3 out of range)
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR*2-1:0] req_afe = '0;
  logic [NR-1:0]   ack;
  logic            busy;
  logic [1:0]      gidx;
  logic [NA-1:0]   sclk, ssdi, sle;

  afe_spi_arbiter #(.NUM_REQ(NR), .NUM_AFE(NA), .WORD_WIDTH(W), .CLK_DIV(H)) dut (
    .sysClk(clk), .sysReset(rst), .req(req), .reqData(req_data), .reqAfe(req_afe),
    .ack(ack), .busy(busy), .grantIdx(gidx), .spiClk(sclk), .spiSdi(ssdi), .spiLe(sle)
  );

  // second DUT: minimum divider
  logic [1:0]  r1_req = '0;
  logic [31:0] r1_data = '0;
  logic [1:0]  r1_afe = '0;
  logic [1:0]  ack1;
  logic        b1;
  logic [0:0]  g1;
  logic [1:0]  clk1, sdi1, le1;

  afe_spi_arbiter #(.NUM_REQ(2), .NUM_AFE(2), .WORD_WIDTH(16), .CLK_DIV(1)) dut1 (
    .sysClk(clk), .sysReset(rst), .req(r1_req), .reqData(r1_data), .reqAfe(r1_afe),
    .ack(ack1), .busy(b1), .grantIdx(g1), .spiClk(clk1), .spiSdi(sdi1), .spiLe(le1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one transaction described by its start offset
  bit        active = 0;
  int        cyc_off = 0;
  int        w_cur = 0;
  int        a_cur = 0;
  logic [W-1:0] d_cur = '0;
  int        lastg = NR - 1;
  int        exp_gidx = 0;

  // Expected pins from the slot number s = offset / H:
  // 0 setup, odd 1..31 clock high, even 2..32 clock low, 33 latch, 34 gap.
  task automatic check_cycle();
    logic [NA-1:0] eclk, esdi, ele;
    logic [NR-1:0] eack;
    logic          ebusy;
    int            s, j;
    eclk = '0; esdi = '0; ele = '0; eack = '0; ebusy = 1'b0;
    if (active) begin
      ebusy = 1'b1;
      s = cyc_off / H;
      if (s >= 1 && s <= 32 && (s % 2) == 1) eclk[a_cur] = 1'b1;
      if (s <= 32) begin
        j = s / 2;
        if (j < W && d_cur[W-1-j]) esdi[a_cur] = 1'b1;
      end
      if (s == 33) ele[a_cur] = 1'b1;
      if (cyc_off == 34 * H) eack[w_cur] = 1'b1;
    end
    check("busy", 32'(busy), 32'(ebusy));
    check("grant", 32'(gidx), 32'(exp_gidx));
    check("spi_clk", 32'(sclk), 32'(eclk));
    check("spi_sdi", 32'(ssdi), 32'(esdi));
    check("spi_le", 32'(sle), 32'(ele));
    check("ack", 32'(ack), 32'(eack));
  endtask

  task automatic drive();
    int inflight;
    inflight = active ? w_cur : -1;
    if (active && cyc_off == 34 * H) req[w_cur] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (i == inflight) begin
        // changes after grant must not affect the word on the wire
        if ($urandom_range(0, 31) == 0) req_data[i*W +: W] = 16'($urandom);
        if (req[i] && $urandom_range(0, 127) == 0) req[i] = 1'b0;
      end else if (!req[i]) begin
        if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = 16'($urandom);
          req_afe[i*2 +: 2] = 2'($urandom_range(0, 3));
        end
      end else if ($urandom_range(0, 63) == 0) begin
        req_data[i*W +: W] = 16'($urandom);
      end
    end
  endtask

  // Decide what the DUT does in the next cycle given the req it will sample.
  task automatic plan_next();
    int w;
    int a;
    if (active) begin
      if (cyc_off == 35 * H - 1) active = 0;
      else cyc_off++;
    end else if (req != '0) begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        if (w < 0 && req[(lastg + k) % NR]) w = (lastg + k) % NR;
      end
      a = int'(req_afe[w*2 +: 2]);
      active = 1;
      cyc_off = 0;
      w_cur = w;
      d_cur = req_data[w*W +: W];
      a_cur = (a >= NA) ? 0 : a;
      lastg = w;
      exp_gidx = w;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive();
    plan_next();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_grant"}, 32'(gidx), 32'd0);
    check({tag, "_pins"}, 32'({sclk, ssdi, sle}), 32'd0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n;
    int t, busy_n, le_n, ack_n, ack_at, clk_n, toggles, afe0_bad;
    logic [15:0] bits;
    logic prev_clk;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_b1", 32'({b1, ack1, clk1, sdi1, le1}), 32'd0);
    rst = 1'b0;
    plan_next();

    // random traffic
    for (int c = 0; c < 3000; c++) step();

    // run until the next cycle is the clock-high phase of bit 7, then reset
    n = 0;
    while (!(active && (cyc_off / H) == 15) && n < 3000) begin
      step();
      n++;
    end
    check("rst_reach", 32'(n < 3000), 32'd1);
    @(negedge clk);
    check_cycle();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    active = 0;
    lastg = NR - 1;
    exp_gidx = 0;
    req[0] = 1'b1;
    req[1] = 1'b1;
    req_data[0 +: W] = 16'($urandom);
    req_afe[0 +: 2] = 2'($urandom_range(0, 3));
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    rst = 1'b0;
    plan_next();
    for (int c = 0; c < 1500; c++) step();

    // drain main DUT
    req = '0;
    n = 0;
    while (active && n < 200) begin
      step();
      req = '0;
      n++;
    end

    // divider of 1: single word 0xA5C3 to AFE 1
    r1_data[15:0] = 16'hA5C3;
    r1_afe[0] = 1'b1;
    @(negedge clk);
    r1_req = 2'b01;
    t = 0;
    while (!b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("h1_grant", 32'(b1), 32'd1);
    busy_n = 0; le_n = 0; ack_n = 0; ack_at = -1; clk_n = 0; toggles = 0; afe0_bad = 0;
    bits = '0;
    prev_clk = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b1) busy_n++;
      if (le1[1]) le_n++;
      if (ack1 != 2'b00) begin
        ack_n++;
        if (ack1 == 2'b01) ack_at = c;
        r1_req = 2'b00;
      end
      if (clk1[1] && !prev_clk) begin
        bits = {bits[14:0], sdi1[1]};
        clk_n++;
      end
      if (clk1[1] != prev_clk) toggles++;
      prev_clk = clk1[1];
      if (clk1[0] | sdi1[0] | le1[0]) afe0_bad++;
      @(negedge clk);
    end
    check("h1_busy_len", 32'(busy_n), 32'd35);
    check("h1_le_len", 32'(le_n), 32'd1);
    check("h1_ack_cnt", 32'(ack_n), 32'd1);
    check("h1_ack_at", 32'(ack_at), 32'd34);
    check("h1_edges", 32'(clk_n), 32'd16);
    check("h1_toggles", 32'(toggles), 32'd32);
    check("h1_word", 32'(bits), 32'hA5C3);
    check("h1_afe0", 32'(afe0_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
